// File: rtl/game_text_ctrl.sv
// game_text_ctrl: game flow FSM and frame-synchronous text overlay select.
// Optional macro TEXT_BLINK_EN enables blinking of the IDLE/OVER_WAIT text.
module game_text_ctrl #(
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic       start_btn,
  output logic       show_text,
  output logic [1:0] msg_sel,
  output logic       game_run
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER_HOLD,
    OVER_WAIT
  } state_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          entry;
  logic          blink_on;
  logic          show_nx;
  logic [1:0]    msg_nx;

  assign hold_done = frame_tick &&
                     (hold_cnt == HW'(HOLD_FRAMES - 1));
  assign entry     = (state_nx != state);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and frame-latched text targets
  always_comb begin
    state_nx = state;
    show_nx  = 1'b0;
    msg_nx   = 2'd0;
    unique case (state)
      IDLE: begin
        msg_nx  = 2'd1;
        show_nx = blink_on;
        if (start_btn) state_nx = RUN;
      end
      RUN: begin
        if (game_over) state_nx = OVER_HOLD;
      end
      OVER_HOLD: begin
        msg_nx  = 2'd2;
        show_nx = 1'b1;
        if (hold_done) state_nx = OVER_WAIT;
      end
      OVER_WAIT: begin
        msg_nx  = 2'd2;
        show_nx = blink_on;
        if (start_btn) state_nx = IDLE;
      end
    endcase
  end

  // hold counter: only advances on ticks while holding GAME OVER
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hold_cnt <= '0;
    else if (entry)
      hold_cnt <= '0;
    else if (state == OVER_HOLD && frame_tick)
      hold_cnt <= hold_cnt + HW'(1);
  end

`ifdef TEXT_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;

  // blink phase generator, restarted visible on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (entry) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blink_on = phase;
`else
  assign blink_on = 1'b1;
`endif

  // registered outputs; text only changes right after a frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      show_text <= 1'b0;
      msg_sel   <= 2'd0;
      game_run  <= 1'b0;
    end else begin
      game_run <= (state_nx == RUN);
      if (frame_tick) begin
        show_text <= show_nx;
        msg_sel   <= msg_nx;
      end
    end
  end

endmodule

// File: tb/tb_game_text_ctrl.sv
// tb_game_text_ctrl: directed checks of game_text_ctrl
// with HOLD_FRAMES=4, BLINK_FRAMES=2.
module tb_game_text_ctrl;

`ifdef TEXT_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic       start_btn = 1'b0;
  logic       show_text;
  logic [1:0] msg_sel;
  logic       game_run;

  int n_cmp = 0;
  int n_err = 0;

  game_text_ctrl #(
    .HOLD_FRAMES (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .game_over (game_over),
    .start_btn (start_btn),
    .show_text (show_text),
    .msg_sel   (msg_sel),
    .game_run  (game_run)
  );

  always #5 clk = ~clk;

  // k = tick index since state entry, 0-based
  function automatic logic blink_exp(input int k);
    if (!BLINK) return 1'b1;
    return ((k / 2) % 2) == 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic s,
                         input logic [1:0] m,
                         input logic r);
    chk({tag, ".show"}, {3'b0, show_text}, {3'b0, s});
    chk({tag, ".msg"},  {2'b0, msg_sel},   {2'b0, m});
    chk({tag, ".run"},  {3'b0, game_run},  {3'b0, r});
  endtask

  // one clock with the given input pulses; sample 1ns after the edge
  task automatic step(input logic t, input logic s,
                      input logic g);
    @(negedge clk);
    frame_tick = t;
    start_btn  = s;
    game_over  = g;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    game_over  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step(1'b0, 1'b0, 1'b1);
    chk_out("idle_go_ignored", 1'b0, 2'd0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_out($sformatf("idle_tick%0d", k + 1),
              blink_exp(k), 2'd1, 1'b0);
    end

    step(1'b0, 1'b1, 1'b0);
    chk_out("start_run", blink_exp(3), 2'd1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk_out("run_start_ignored", blink_exp(3), 2'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk_out("run_tick", 1'b0, 2'd0, 1'b1);

    step(1'b0, 1'b1, 1'b1);
    chk_out("over_wins", 1'b0, 2'd0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_out($sformatf("hold_tick%0d", k + 1),
              1'b1, 2'd2, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk_out("hold_start_ignored", 1'b1, 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_out("hold_tick4", 1'b1, 2'd2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk_out($sformatf("wait_tick%0d", k + 1),
              blink_exp(k), 2'd2, 1'b0);
    end

    step(1'b0, 1'b1, 1'b0);
    chk_out("wait_start", blink_exp(3), 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_out("back_idle_tick", 1'b1, 2'd1, 1'b0);

    step(1'b0, 1'b1, 1'b0);
    chk_out("run_again", 1'b1, 2'd1, 1'b1);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_out($sformatf("post_reset_tick%0d", k + 1),
              blink_exp(k), 2'd1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_text_ctrl.md
GAME_TEXT_CTRL -- requirements
Module: game_text_ctrl

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 120: frames "GAME OVER" shows steadily before a restart is accepted; legal range 1..1023.
REQ-002 SHALL have parameter BLINK_FRAMES, default 30: frames per blink half-period; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system/pixel clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at the start of each VGA frame (v_cnt wrap).
REQ-006 SHALL have port game_over  input  1  level or pulse; sampled every cycle.
REQ-007 SHALL have port start_btn  input  1  debounced one-cycle pulse.
REQ-008 SHALL have port show_text  output  1  enables the text overlay.
REQ-009 SHALL have port msg_sel  output  2  message index: 0 = none, 1 = "PRESS START", 2 = "GAME OVER", 3 = reserved, never driven.
REQ-010 SHALL have port game_run  output  1  high while gameplay is active.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN, OVER_HOLD and OVER_WAIT.
REQ-012 IDLE: start_btn -> RUN on the next edge; other inputs ignored.
REQ-013 RUN: game_over -> OVER_HOLD; start_btn ignored; game_over wins if both are asserted in the same cycle.
REQ-014 OVER_HOLD: a frame counter clears on entry and increments on each frame_tick; leave for OVER_WAIT on the frame_tick that makes count == HOLD_FRAMES; start_btn ignored.
REQ-015 OVER_WAIT: start_btn -> IDLE; game_over ignored.
REQ-016 game_run SHALL be a registered output, high exactly while the state is RUN, updating the cycle after the state change.
REQ-017 show_text and msg_sel SHALL update only in the cycle after a frame_tick, so text never changes mid-frame; between ticks they hold.
REQ-018 On a frame_tick, targets latched from the current state are: IDLE -> msg 1, show = blink phase; RUN -> msg 0, show 0; OVER_HOLD -> msg 2, show 1; OVER_WAIT -> msg 2, show = blink phase.
REQ-019 Blink phase SHALL be a 1-bit toggle driven by a blink counter that increments on frame_tick, toggles the phase and clears when it reaches BLINK_FRAMES-1; counter clears to 0 and phase sets to 1 on every state entry.
REQ-020 A frame_tick coincident with a state transition SHALL latch outputs from the pre-transition state; the new state takes effect at the next frame_tick.
REQ-021 Counters SHALL be sized from the parameters, with no wrap before terminal count; a frame_tick outside OVER_HOLD SHALL NOT advance the hold counter.
REQ-022 When show_text is 0, msg_sel SHALL still reflect the state's message, except in RUN, where it is 0.

Reset
REQ-023 Reset SHALL force: state IDLE; hold counter 0; blink counter 0; phase 1; show_text 0; msg_sel 0; game_run 0.
REQ-024 Reset asserted mid-operation (any state, any counter value) SHALL take effect immediately and asynchronously; the first post-reset frame_tick yields show_text 1, msg_sel 1.

Configuration
REQ-025 Macro TEXT_BLINK_EN SHALL gate blinking. Defined: behaviour per REQ-018/019. Undefined: blink counter and phase absent, show_text = 1 in IDLE and OVER_WAIT, all other behaviour identical.

Verification (HOLD_FRAMES=4, BLINK_FRAMES=2, TEXT_BLINK_EN defined unless noted)
REQ-026 Reset, then 4 frame_ticks in IDLE -> show_text sequence 1,1,0,0 after ticks 1..4 (counter reaches BLINK_FRAMES-1 on tick 2 and toggles; phase 0 on ticks 3,4); msg_sel 1 throughout; game_run 0.
REQ-027 start_btn in IDLE -> game_run 1 next cycle; next frame_tick -> show_text 0, msg_sel 0; game_over and start_btn in the same cycle -> OVER_HOLD, game_run 0.
REQ-028 In OVER_HOLD, start_btn pulses on ticks 1-3 are ignored; after tick 4 the state is OVER_WAIT; outputs show 1/msg 2 after ticks 1-4, then blink.
REQ-029 start_btn in OVER_WAIT -> IDLE; the next frame_tick gives msg_sel 1, show_text 1.
REQ-030 Reset asserted in RUN between ticks -> all outputs 0 the same cycle; with TEXT_BLINK_EN undefined, IDLE show_text stays 1 for 6 consecutive ticks.
